// File: rtl/uart_csr_bank.sv
// rtl/uart_csr_bank.sv - per-channel UART control/status register bank behind a valid/ready request/response bus
//
// Optional feature: define UART_CSR_IRQ_EN to build the interrupt logic and the IRQ_MASK register.
// Without it, irq is tied low, IRQ_MASK reads 0 and writes to it are dropped.
//
// Register map per channel (req_addr[1:0] = offset, upper address bits = channel):
//   0 BAUD     RW  [BAUD_W-1:0]
//   1 CONTROL  RW  [4:0] tx_en, rx_en, par_en, par_odd, stop2; [7:5] read 0
//   2 STATUS   [0] busy (live), [1] free (live), [2] perr_sticky (W1C), [15:8] perr_cnt
//   3 IRQ_MASK RW  [2:0] perr_sticky, busy fall, free rise
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready/req_we    request handshake and direction
//   req_addr, req_wdata           register address and write data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            read data (0 for writes/errors), access error
//   baud_rate, control            per-channel configuration outputs
//   busy, free, parity_error      per-channel status inputs
//   irq                           registered interrupt
module uart_csr_bank #(
  parameter int N_CH     = 4,
  parameter int BAUD_W   = 16,
  parameter int BAUD_RST = 868,
  localparam int ADDR_W  = $clog2(N_CH) + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [N_CH*BAUD_W-1:0]   baud_rate,
  output logic [N_CH*8-1:0]        control,
  input  logic [N_CH-1:0]          busy,
  input  logic [N_CH-1:0]          free,
  input  logic [N_CH-1:0]          parity_error,
  output logic                     irq
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [BAUD_W-1:0]   baud_q [N_CH];
  logic [BAUD_W-1:0]   baud_d [N_CH];
  logic [4:0]          ctrl_q [N_CH];
  logic [4:0]          ctrl_d [N_CH];
  logic [7:0]          cnt_q  [N_CH];
  logic [7:0]          cnt_d  [N_CH];
  logic [N_CH-1:0]     sticky_q, sticky_d;
  logic [N_CH-1:0]     perr_prev_q;

  logic                accept;
  logic [ADDR_W-1:0]   ch_sel;
  logic [1:0]          off;
  logic [N_CH-1:0]     hit;
  logic [N_CH-1:0]     w1c;
  logic [N_CH-1:0]     perr_rise;
  logic [31:0]         rd_val;
  logic                unused_wdata;

  assign unused_wdata = ^req_wdata;

  assign accept = req_valid && (state_q == S_IDLE);
  assign ch_sel = req_addr >> 2;
  assign off    = req_addr[1:0];

  // One-hot channel decode; an out-of-range channel leaves hit all-zero,
  // which is what flags the error and blocks every state update.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (ch_sel == ADDR_W'(i));
    end
  end

`ifdef UART_CSR_IRQ_EN
  logic [2:0]      mask_q [N_CH];
  logic [2:0]      mask_d [N_CH];
  logic [N_CH-1:0] busy_prev_q, free_prev_q;
  logic [N_CH-1:0] evt_q, evt_d;
  logic            irq_q, irq_d;

  // Busy-fall and free-rise pulses are masked at the moment they happen and
  // latched into one sticky event bit per channel; W1C of STATUS[2] clears it,
  // but a pulse in the same cycle wins.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      mask_d[i] = mask_q[i];
      if (accept && req_we && hit[i] && off == 2'd3) begin
        mask_d[i] = req_wdata[2:0];
      end
      if ((mask_q[i][1] && busy_prev_q[i] && !busy[i]) ||
          (mask_q[i][2] && free[i] && !free_prev_q[i])) begin
        evt_d[i] = 1'b1;
      end else if (w1c[i]) begin
        evt_d[i] = 1'b0;
      end else begin
        evt_d[i] = evt_q[i];
      end
      // Built from next-state so irq moves on the same edge as the sticky bits.
      irq_d = irq_d | (mask_d[i][0] & sticky_d[i]) | evt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        mask_q[i] <= '0;
      end
      busy_prev_q <= '0;
      free_prev_q <= '0;
      evt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mask_q[i] <= mask_d[i];
      end
      busy_prev_q <= busy;
      free_prev_q <= free;
      evt_q       <= evt_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux on the current register contents; sampled only on the accept edge.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (hit[i]) begin
        case (off)
          2'd0: rd_val[BAUD_W-1:0] = baud_q[i];
          2'd1: rd_val[4:0]        = ctrl_q[i];
          2'd2: begin
            rd_val[0]    = busy[i];
            rd_val[1]    = free[i];
            rd_val[2]    = sticky_q[i];
            rd_val[15:8] = cnt_q[i];
          end
          default: begin
`ifdef UART_CSR_IRQ_EN
            rd_val[2:0] = mask_q[i];
`endif
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      baud_d[i]    = baud_q[i];
      ctrl_d[i]    = ctrl_q[i];
      w1c[i]       = accept && req_we && hit[i] && off == 2'd2 && req_wdata[2];
      perr_rise[i] = parity_error[i] && !perr_prev_q[i];
      if (accept && req_we && hit[i] && off == 2'd0) begin
        baud_d[i] = req_wdata[BAUD_W-1:0];
      end
      if (accept && req_we && hit[i] && off == 2'd1) begin
        ctrl_d[i] = req_wdata[4:0];
      end
      // Rising edge beats a simultaneous W1C: the clear happens first and the
      // new edge is then counted, leaving sticky=1, cnt=1.
      if (perr_rise[i]) begin
        sticky_d[i] = 1'b1;
        if (w1c[i]) begin
          cnt_d[i] = 8'd1;
        end else if (cnt_q[i] == 8'hFF) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else if (w1c[i]) begin
        sticky_d[i] = 1'b0;
        cnt_d[i]    = 8'd0;
      end else begin
        sticky_d[i] = sticky_q[i];
        cnt_d[i]    = cnt_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_RESP;
          err_d   = ~|hit;
          rdata_d = (req_we || ~|hit) ? 32'd0 : rd_val;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      sticky_q    <= '0;
      perr_prev_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        baud_q[i] <= BAUD_W'(BAUD_RST);
        ctrl_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      perr_prev_q <= parity_error;
      for (int i = 0; i < N_CH; i++) begin
        baud_q[i] <= baud_d[i];
        ctrl_q[i] <= ctrl_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign baud_rate[g*BAUD_W +: BAUD_W] = baud_q[g];
    assign control[g*8 +: 8]             = {3'b000, ctrl_q[g]};
  end

endmodule

// File: tb/tb_uart_csr_bank.sv
// tb/tb_uart_csr_bank.sv - scoreboard bench for uart_csr_bank (4-channel and 3-channel instances on one bus)
module tb_uart_csr_bank;

`ifdef UART_CSR_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  busy, free, parity;

  logic        req_ready, rsp_valid, rsp_err, irq;
  logic [31:0] rsp_rdata;
  logic [63:0] baud_rate;
  logic [31:0] control;

  logic        req_ready3, rsp_valid3, rsp_err3, irq3;
  logic [31:0] rsp_rdata3;
  logic [47:0] baud_rate3;
  logic [23:0] control3;

  uart_csr_bank #(.N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .baud_rate(baud_rate), .control(control),
    .busy(busy), .free(free), .parity_error(parity), .irq(irq)
  );

  uart_csr_bank #(.N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .baud_rate(baud_rate3), .control(control3),
    .busy(busy[2:0]), .free(free[2:0]), .parity_error(parity[2:0]), .irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] d; logic e; } rsp_t;
  rsp_t q4[$];
  rsp_t q3[$];

  int   m_baud[4], m_ctrl[4], m_mask[4], m_cnt[4];
  bit   m_sticky[4], m_evt[4];
  logic [3:0] m_pprev, m_bprev, m_fprev;
  bit   m_out, m_irq, m_irq3;
  int   m_acc = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int ch, off;
    bit [3:0] clr;
    int old_mask[4];
    rsp_t r;
    bit any4, any3;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_baud[i] = 868; m_ctrl[i] = 0; m_mask[i] = 0; m_cnt[i] = 0;
        m_sticky[i] = 0; m_evt[i] = 0;
      end
      m_pprev = 0; m_bprev = 0; m_fprev = 0;
      m_out = 0; m_irq = 0; m_irq3 = 0;
      q4.delete(); q3.delete();
    end else begin
      clr = '0;
      old_mask = m_mask;
      if (m_out) begin
        if (rsp_ready) m_out = 0;
      end else if (req_valid) begin
        ch = int'(req_addr[3:2]);
        off = int'(req_addr[1:0]);
        r.d = '0; r.e = 1'b0;
        if (!req_we) begin
          case (off)
            0: r.d = m_baud[ch];
            1: r.d = m_ctrl[ch];
            2: r.d = {16'd0, 8'(m_cnt[ch]), 5'd0, m_sticky[ch], free[ch], busy[ch]};
            default: r.d = IRQ_EN ? m_mask[ch] : 0;
          endcase
        end else begin
          case (off)
            0: m_baud[ch] = int'(req_wdata[15:0]);
            1: m_ctrl[ch] = int'(req_wdata[4:0]);
            2: clr[ch] = req_wdata[2];
            default: if (IRQ_EN) m_mask[ch] = int'(req_wdata[2:0]);
          endcase
        end
        q4.push_back(r);
        if (ch == 3) begin r.d = '0; r.e = 1'b1; end
        q3.push_back(r);
        m_out = 1;
        m_acc++;
      end
      any4 = 0; any3 = 0;
      for (int i = 0; i < 4; i++) begin
        if (parity[i] && !m_pprev[i]) begin
          m_sticky[i] = 1;
          m_cnt[i] = clr[i] ? 1 : (m_cnt[i] < 255 ? m_cnt[i] + 1 : 255);
        end else if (clr[i]) begin
          m_sticky[i] = 0;
          m_cnt[i] = 0;
        end
        if ((old_mask[i][1] && m_bprev[i] && !busy[i]) || (old_mask[i][2] && free[i] && !m_fprev[i]))
          m_evt[i] = 1;
        else if (clr[i])
          m_evt[i] = 0;
        if ((m_mask[i][0] && m_sticky[i]) || m_evt[i]) begin
          any4 = 1;
          if (i < 3) any3 = 1;
        end
      end
      m_irq  = IRQ_EN && any4;
      m_irq3 = IRQ_EN && any3;
      m_pprev = parity; m_bprev = busy; m_fprev = free;
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] last_d4, last_d3;
  logic        last_e4, last_e3;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, !m_out);
      chk("req_ready3", req_ready3, !m_out);
      chk("rsp_valid", rsp_valid, m_out);
      chk("rsp_valid3", rsp_valid3, m_out);
      if (rsp_valid) begin
        if (q4.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_rdata", rsp_rdata, q4[0].d);
          chk("rsp_err", rsp_err, q4[0].e);
          if (rsp_ready) begin
            last_d4 = rsp_rdata; last_e4 = rsp_err;
            void'(q4.pop_front());
          end
        end
      end
      if (rsp_valid3) begin
        if (q3.size() == 0) chk("rsp3_unexpected", 1, 0);
        else begin
          chk("rsp3_rdata", rsp_rdata3, q3[0].d);
          chk("rsp3_err", rsp_err3, q3[0].e);
          if (rsp_ready) begin
            last_d3 = rsp_rdata3; last_e3 = rsp_err3;
            void'(q3.pop_front());
          end
        end
      end
      chk("irq", irq, m_irq);
      chk("irq3", irq3, m_irq3);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("baud%0d", i), baud_rate[i*16 +: 16], m_baud[i]);
        chk($sformatf("ctrl%0d", i), control[i*8 +: 8], m_ctrl[i]);
        if (i < 3) begin
          chk($sformatf("baud3_%0d", i), baud_rate3[i*16 +: 16], m_baud[i]);
          chk($sformatf("ctrl3_%0d", i), control3[i*8 +: 8], m_ctrl[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_en = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_en) begin
      busy      = 4'($urandom);
      free      = 4'($urandom);
      parity    = 4'($urandom) & 4'($urandom) & 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_accept(input int n0);
    for (int k = 0; k < 60 && m_acc == n0; k++) tick();
    if (m_acc == n0) begin
      n_total++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    req_valid = 1'b0;
  endtask

  task automatic access(input bit we, input logic [3:0] addr, input logic [31:0] wd);
    int n0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n0 = m_acc;
    wait_accept(n0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && m_out; k++) tick();
    if (m_out) begin
      n_total++;
      $display("FAIL drain_timeout: got pending expected idle");
    end
  endtask

  int saved_baud;

  initial begin
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 1; busy = 0; free = 0; parity = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_irq", irq, 0);
    chk("rst_baud", baud_rate, {4{16'd868}});
    chk("rst_ctrl", control, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    tick();

    // reset value readback
    access(0, 4'h0, 0); drain();
    chk("rd_baud_rst", last_d4, 868);
    chk("rd_baud_rst_err", last_e4, 0);

    // ch3 CONTROL write/read, others untouched; ch3 is out of range on the 3-channel instance
    access(1, 4'hD, 32'hFF);
    access(0, 4'hD, 0); drain();
    chk("ctrl3_rd", last_d4, 32'h1F);
    chk("ctrl3_rd_err3", last_e3, 1);
    chk("ctrl3_rd_data3", last_d3, 0);
    chk("ctrl_ch012", control[23:0], 0);
    chk("baud_ch012", baud_rate[47:0], {3{16'd868}});
    access(0, 4'hC, 0); drain();
    chk("err_addr_c", last_e3, 1);
    chk("err_addr_c_data", last_d3, 0);
    chk("ok_addr_c_4ch", last_e4, 0);

    // randomized traffic
    rnd_en = 1;
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom), 4'($urandom), $urandom);
    end
    rnd_en = 0;
    rsp_ready = 1; busy = 0; free = 0; parity = 0;
    drain(); tick(); tick();

    // parity counting saturation and set-wins-over-W1C
    for (int n = 0; n < 300; n++) begin
      parity = 4'b0010; tick();
      parity = 4'b0000; tick();
    end
    access(0, 4'h6, 0); drain();
    chk("perr_sat", last_d4, 32'h0000FF04);
    parity = 4'b0010;
    access(1, 4'h6, 32'h4);
    parity = 4'b0000;
    drain();
    access(0, 4'h6, 0); drain();
    chk("perr_w1c_set", last_d4, 32'h00000104);

    // backpressure: response held, second request parked
    saved_baud = m_baud[0];
    rsp_ready = 0;
    access(0, 4'h0, 0);
    req_valid = 1; req_we = 1; req_addr = 4'h0; req_wdata = 32'h0001_1234;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rdata", rsp_rdata, saved_baud);
      chk("bp_baud_hold", baud_rate[15:0], saved_baud);
    end
    rsp_ready = 1;
    wait_accept(m_acc);
    drain();
    chk("bp_write_late", baud_rate[15:0], 16'h1234);

    // interrupt
    for (int i = 0; i < 4; i++) access(1, 4'(i*4 + 3), 0);
    for (int i = 0; i < 4; i++) access(1, 4'(i*4 + 2), 32'h4);
    access(1, 4'hB, 32'h1); drain();
    parity = 4'b0100; tick();
    parity = 4'b0000;
    chk("irq_set", irq, IRQ_EN);
    chk("irq3_set", irq3, IRQ_EN);
    access(1, 4'hA, 32'h4); drain();
    chk("irq_clr", irq, 0);
    chk("irq3_clr", irq3, 0);

    // reset in the middle of a response
    rsp_ready = 0;
    access(0, 4'h1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_valid3", rsp_valid3, 0);
    tick(); tick();
    rst_n = 1'b1; rsp_ready = 1;
    tick();
    chk("postrst_req_ready", req_ready, 1);
    chk("postrst_rsp_valid", rsp_valid, 0);
    access(0, 4'h0, 0); drain();
    chk("postrst_baud", last_d4, 868);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_csr_bank.md
UART_CSR_BANK -- requirements
Module: uart_csr_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of UART channels (1..16).
REQ-002 SHALL have parameter BAUD_W, default 16: baud divisor width.
REQ-003 SHALL have parameter BAUD_RST, default 868: baud divisor reset value.
REQ-004 SHALL have the local ADDR_W = $clog2(N_CH)+2; addr[1:0] is the register offset and the upper bits are the channel.
REQ-005 SHALL have the following ports:
  clk  in  1  sole clock.
  rst_n  in  1  async active-low reset.
  req_valid  in  1  bus request valid.
  req_ready  out  1  bus request accepted.
  req_we  in  1  1=write, 0=read.
  req_addr  in  ADDR_W  register address.
  req_wdata  in  32  write data.
  rsp_valid  out  1  response valid.
  rsp_ready  in  1  response consumed.
  rsp_rdata  out  32  read data (0 for writes).
  rsp_err  out  1  access error.
  baud_rate  out  N_CH*BAUD_W  per-channel divisor, channel i at [i*BAUD_W +: BAUD_W].
  control  out  N_CH*8  per-channel control byte.
  busy  in  N_CH  per-channel busy flag.
  free  in  N_CH  per-channel free flag.
  parity_error  in  N_CH  per-channel parity error flag.
  irq  out  1  interrupt (see Configuration).

Function
REQ-006 SHALL implement FSM IDLE/RESP: req_ready=1 only in IDLE; req_valid&&req_ready moves IDLE->RESP; rsp_valid=1 in RESP; rsp_valid&&rsp_ready moves RESP->IDLE; exactly one outstanding access.
REQ-007 SHALL commit writes on the accept edge, capture read data on the accept edge, and hold rsp_rdata/rsp_err stable while in RESP.
REQ-008 SHALL use these offsets: 0=BAUD (RW, [BAUD_W-1:0]); 1=CONTROL (RW, [7:0]: 0 tx_en, 1 rx_en, 2 par_en, 3 par_odd, 4 stop2, 7:5 reserved and read 0); 2=STATUS; 3=IRQ_MASK (RW, [2:0]).
REQ-009 SHALL define STATUS as [0] busy (RO, live), [1] free (RO, live), [2] perr_sticky (W1C), [15:8] perr_cnt (RO, cleared by W1C of bit 2); all other bits read 0.
REQ-010 SHALL set perr_sticky and increment perr_cnt on each rising edge of parity_error[i], detected against a registered copy; perr_cnt saturates at 255.
REQ-011 SHALL give set priority when a rising edge and a W1C occur in the same cycle: the result is sticky=1 and cnt=1.
REQ-012 SHALL treat channel index >= N_CH as an error: rsp_err=1, rdata=0, no state change; writes to STATUS bits other than bit 2 are ignored without error.
REQ-013 SHALL ignore write bits above each field width.

Reset
REQ-014 SHALL on rst_n low asynchronously force: FSM=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, baud=BAUD_RST, control=0, IRQ_MASK=0, sticky=0, cnt=0, edge regs=0, irq=0.
REQ-015 SHALL, on reset asserted mid-access, discard the pending response; after release the block is in IDLE with req_ready=1.

Configuration
REQ-016 SHALL use UART_CSR_IRQ_EN to control the interrupt. When defined: irq is registered and equals OR over channels of (mask[0]&perr_sticky | mask[1]&busy fall edge | mask[2]&free rise edge), the latter two as 1-cycle pulses folded into a per-channel sticky event cleared by W1C of STATUS bit 2. When undefined: irq is tied 0, IRQ_MASK reads 0, and writes to it are ignored.

Verification
REQ-017 SHALL check reset: read ch0 BAUD -> rdata=868, err=0, one cycle after accept.
REQ-018 SHALL check write/read: write ch3 CONTROL=0xFF, read it back -> 0x1F; baud_rate/control of ch0-2 unchanged.
REQ-019 SHALL check parity counting: 300 parity_error pulses on ch1 -> STATUS[15:8]=255 and [2]=1; W1C 0x4 coinciding with a pulse -> sticky=1, cnt=1.
REQ-020 SHALL check backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, data stable, req_ready=0; new req_valid is not accepted.
REQ-021 SHALL check errors: with N_CH=3, access addr 0xC -> rsp_err=1, rdata=0; reset mid-RESP -> rsp_valid=0 immediately.
REQ-022 SHALL check the interrupt with UART_CSR_IRQ_EN: mask=1, parity pulse on ch2 -> irq=1 next cycle, W1C -> irq=0; without the macro irq stays 0.
